// File: rtl/sqrt_nr_pipe_ctrl_if.sv
// Handshake bundle for the multicycle square-root unit: radicand in, root/remainder out.
interface sqrt_nr_pipe_ctrl_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] d;
  logic          cancel;
  logic          out_valid;
  logic          out_ready;
  logic [DW/2-1:0] q;
  logic [DW/2:0]   r;
  logic          busy;

  modport master (
    output in_valid, d, cancel, out_ready,
    input  in_ready, out_valid, q, r, busy
  );

  modport slave (
    input  in_valid, d, cancel, out_ready,
    output in_ready, out_valid, q, r, busy
  );
endinterface

// File: rtl/sqrt_nr_pipe_ctrl.sv
// Multicycle non-restoring integer square root: q = floor(sqrt(d)), r = d - q*q.
// Resolves SPC root bits per clock; result registered and held until taken.
//
// state  | meaning
// S_IDLE | waiting for a radicand, in_ready high
// S_RUN  | iterating, SPC root bits per edge
// S_DONE | result valid, held until out_ready
module sqrt_nr_pipe_ctrl #(
  parameter int DW  = 32,
  parameter int SPC = 1
) (
  input logic               clock,
  input logic               resetn,
  sqrt_nr_pipe_ctrl_if.slave bus
);

  localparam int QW = DW / 2;
  localparam int RW = QW + 2;
  localparam int N  = DW / (2 * SPC);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] rad_q, rad_d;
  logic [QW-1:0] pq_q, pq_d;
  logic [RW-1:0] pr_q, pr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [QW-1:0] q_out_q, q_out_d;
  logic [QW:0]   r_out_q, r_out_d;

  logic [DW-1:0] rad_n;
  logic [QW-1:0] pq_n;
  logic [RW-1:0] pr_n;
  logic [RW-1:0] pr_fix;
  logic          in_ready_c;

  // SPC non-restoring steps on the partial root/remainder, plus final remainder fixup.
  // The remainder is kept modulo 2^RW; intermediate shifts may wrap but every stored
  // value fits the signed range, so the sign bit stays exact.
  always_comb begin
    rad_n = rad_q;
    pq_n  = pq_q;
    pr_n  = pr_q;
    for (int s = 0; s < SPC; s++) begin
      if (pr_n[RW-1]) begin
        pr_n = {pr_n[RW-3:0], rad_n[DW-1:DW-2]} + {pq_n, 2'b11};
      end else begin
        pr_n = {pr_n[RW-3:0], rad_n[DW-1:DW-2]} - {pq_n, 2'b01};
      end
      pq_n  = {pq_n[QW-2:0], ~pr_n[RW-1]};
      rad_n = {rad_n[DW-3:0], 2'b00};
    end
    pr_fix = pr_n[RW-1] ? (pr_n + {1'b0, pq_n, 1'b1}) : pr_n;
  end

  // Next-state and datapath update; cancel overrides everything and blocks acceptance.
  always_comb begin
    state_d    = state_q;
    rad_d      = rad_q;
    pq_d       = pq_q;
    pr_d       = pr_q;
    cnt_d      = cnt_q;
    q_out_d    = q_out_q;
    r_out_d    = r_out_q;
    in_ready_c = ~bus.cancel &
                 ((state_q == S_IDLE) | ((state_q == S_DONE) & bus.out_ready));

    if (bus.cancel) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (in_ready_c && bus.in_valid) begin
            rad_d   = bus.d;
            pq_d    = '0;
            pr_d    = '0;
            cnt_d   = '0;
            state_d = S_RUN;
          end else if (state_q == S_DONE && bus.out_ready) begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          rad_d = rad_n;
          pq_d  = pq_n;
          pr_d  = pr_n;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            q_out_d = pq_n;
            r_out_d = pr_fix[QW:0];
            state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      rad_q   <= '0;
      pq_q    <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      pq_q    <= pq_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_RUN);
  assign bus.q         = q_out_q;
  assign bus.r         = r_out_q;

endmodule
